// File: rtl/dual_port_memory.sv
// dual_port_memory: one shared word array with a read/write port A and a
// read-only port B. After reset, a hardware sweep zeroes every word before
// Ready rises and requests are accepted. All state updates on the falling
// clock edge. Both ports return data after ReadLatency (1 or 2) with
// one-cycle valid strobes. Port B reads return the old contents when port A
// writes the same address in the same cycle.
//
// Optional feature (macro MEM_COLLISION_DETECT_EN): when defined, o_collision
// pulses with o_valid_b for a port B read that hit a same-cycle port A write.
// In simulation a message is also printed. When undefined, o_collision is
// tied low and no detection logic exists.
//
// Ports:
//   i_clk          clock; state updates on negedge
//   i_reset_n      synchronous active-low reset, sampled on negedge
//   i_din_a        port A write data
//   i_address_a    port A address
//   i_write_en_a   port A write enable, active low (high = read)
//   i_mem_en_a     port A enable, active low
//   i_address_b    port B read address
//   i_mem_en_b     port B read enable, active low
//   o_dout_a       port A read data (holds when no read completes)
//   o_valid_a      one-cycle strobe: o_dout_a holds new data
//   o_dout_b       port B read data (holds when no read completes)
//   o_valid_b      one-cycle strobe: o_dout_b holds new data
//   o_ready        clear sweep done, requests accepted
//   o_collision    same-address A-write/B-read flag, aligned with o_valid_b
module dual_port_memory #(
  parameter int unsigned AddrWidth   = 8,
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned ReadLatency = 1,  // 1 or 2; any other value acts as 1
  parameter bit          WriteFirst  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [DataWidth-1:0] i_din_a,
  input  logic [AddrWidth-1:0] i_address_a,
  input  logic                 i_write_en_a,
  input  logic                 i_mem_en_a,
  input  logic [AddrWidth-1:0] i_address_b,
  input  logic                 i_mem_en_b,
  output logic [DataWidth-1:0] o_dout_a,
  output logic                 o_valid_a,
  output logic [DataWidth-1:0] o_dout_b,
  output logic                 o_valid_b,
  output logic                 o_ready,
  output logic                 o_collision
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  typedef enum logic {StClear, StReady} state_e;

  state_e               r_state, w_state_next;
  logic [AddrWidth-1:0] r_clr_cnt, w_clr_cnt_next;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_accept;
  logic                 w_wr_a, w_rd_a, w_rd_b, w_fire_a;
  logic [DataWidth-1:0] w_data_a;

  // First pipeline stage (final stage when ReadLatency is 1).
  logic                 r_v1_a, r_v1_b;
  logic [DataWidth-1:0] r_d1_a, r_d1_b;

  // ---------------------------------------------------------------------------
  // Clear sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    unique case (r_state)
      StClear: begin
        w_clr_cnt_next = r_clr_cnt + AddrWidth'(1);
        if (r_clr_cnt == {AddrWidth{1'b1}}) w_state_next = StReady;
      end
      StReady: w_state_next = StReady;
      default: w_state_next = StClear;
    endcase
  end

  always_ff @(negedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= StClear;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  assign o_ready = (r_state == StReady);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // A request presented in the same cycle as reset is dropped.
  assign w_accept = o_ready && i_reset_n;
  assign w_wr_a   = w_accept && !i_mem_en_a && !i_write_en_a;
  assign w_rd_a   = w_accept && !i_mem_en_a &&  i_write_en_a;
  assign w_rd_b   = w_accept && !i_mem_en_b;
  assign w_fire_a = w_rd_a || (WriteFirst && w_wr_a);
  assign w_data_a = w_wr_a ? i_din_a : r_mem[i_address_a];

  // ---------------------------------------------------------------------------
  // Storage: sweep write or port A write, never both (sweep owns CLEAR)
  // ---------------------------------------------------------------------------
  always_ff @(negedge i_clk) begin
    if (i_reset_n && (r_state == StClear)) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_a) begin
      r_mem[i_address_a] <= i_din_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Reading r_mem here sees the pre-write contents, which gives
  // read-before-write on a same-address collision.
  // ---------------------------------------------------------------------------
  always_ff @(negedge i_clk) begin
    if (!i_reset_n) begin
      r_v1_a <= 1'b0;
      r_v1_b <= 1'b0;
      r_d1_a <= '0;
      r_d1_b <= '0;
    end else begin
      r_v1_a <= w_fire_a;
      r_v1_b <= w_rd_b;
      if (w_fire_a) r_d1_a <= w_data_a;
      if (w_rd_b)   r_d1_b <= r_mem[i_address_b];
    end
  end

  if (ReadLatency == 2) begin : gen_lat2
    logic                 r_v2_a, r_v2_b;
    logic [DataWidth-1:0] r_d2_a, r_d2_b;

    always_ff @(negedge i_clk) begin
      if (!i_reset_n) begin
        r_v2_a <= 1'b0;
        r_v2_b <= 1'b0;
        r_d2_a <= '0;
        r_d2_b <= '0;
      end else begin
        r_v2_a <= r_v1_a;
        r_v2_b <= r_v1_b;
        if (r_v1_a) r_d2_a <= r_d1_a;
        if (r_v1_b) r_d2_b <= r_d1_b;
      end
    end

    assign o_dout_a  = r_d2_a;
    assign o_valid_a = r_v2_a;
    assign o_dout_b  = r_d2_b;
    assign o_valid_b = r_v2_b;
  end else begin : gen_lat1
    assign o_dout_a  = r_d1_a;
    assign o_valid_a = r_v1_a;
    assign o_dout_b  = r_d1_b;
    assign o_valid_b = r_v1_b;
  end

  // ---------------------------------------------------------------------------
  // Collision detection
  // ---------------------------------------------------------------------------
`ifdef MEM_COLLISION_DETECT_EN
  logic w_coll, r_coll1;

  assign w_coll = w_wr_a && w_rd_b && (i_address_a == i_address_b);

  always_ff @(negedge i_clk) begin
    if (!i_reset_n) r_coll1 <= 1'b0;
    else            r_coll1 <= w_coll;
  end

  if (ReadLatency == 2) begin : gen_coll_lat2
    logic r_coll2;
    always_ff @(negedge i_clk) begin
      if (!i_reset_n) r_coll2 <= 1'b0;
      else            r_coll2 <= r_coll1;
    end
    assign o_collision = r_coll2;
  end else begin : gen_coll_lat1
    assign o_collision = r_coll1;
  end

`ifndef SYNTHESIS
  always @(negedge i_clk) begin
    if (w_coll) $display("%d COLLISION Addr (0x%h)", $time, i_address_a);
  end
`endif
`else
  assign o_collision = 1'b0;
`endif

endmodule
